// File: rtl/stopwatch_seq_ctrl_if.sv
// stopwatch_seq_ctrl_if: button/tick/time inputs and control/display outputs of the stopwatch sequencer
// Ports (master = stimulus side, slave = controller side):
//   btn_start_p, btn_lap_p, tick_usec, time_bcd[15:0]        master -> slave
//   tick_out, cnt_clear, disp_value[15:0], state[1:0],
//   lap_count[$clog2(LAP_DEPTH):0], recall_active             slave -> master
interface stopwatch_seq_ctrl_if #(parameter int LAP_DEPTH = 4);
    logic                       btn_start_p, btn_lap_p, tick_usec;
    logic [15:0]                time_bcd;
    logic                       tick_out, cnt_clear;
    logic [15:0]                disp_value;
    logic [1:0]                 state;
    logic [$clog2(LAP_DEPTH):0] lap_count;
    logic                       recall_active;
    modport master (
        output btn_start_p, btn_lap_p, tick_usec, time_bcd,
        input  tick_out, cnt_clear, disp_value, state, lap_count, recall_active
    );
    modport slave (
        input  btn_start_p, btn_lap_p, tick_usec, time_bcd,
        output tick_out, cnt_clear, disp_value, state, lap_count, recall_active
    );
endinterface

// File: rtl/stopwatch_seq_ctrl.sv
// stopwatch_seq_ctrl: IDLE/RUN/PAUSE/LAP_VIEW sequencer with tick gating, counter clear and lap capture
// Ports: clk, reset_p (async, active-high), bus (stopwatch_seq_ctrl_if.slave).
// Build option: define SW_LAP_RECALL_EN for the LAP_DEPTH circular lap buffer with IDLE recall;
// otherwise only the single frozen lap_hold value exists and lap_count is a 0/1 flag.
module stopwatch_seq_ctrl #(
    parameter int LAP_DEPTH = 4
) (
    input logic                clk,
    input logic                reset_p,
    stopwatch_seq_ctrl_if.slave bus
);
    localparam int AW = $clog2(LAP_DEPTH);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP_VIEW = 2'b11} state_t;
    state_t      state_q, state_d;
    logic        run_en, clr_d, clr_q;
    logic [15:0] lap_hold;
    logic        start, lap, capture, flush;
    // start has priority: a simultaneous lap is dropped
    assign start   = bus.btn_start_p;
    assign lap     = bus.btn_lap_p & ~bus.btn_start_p;
    assign capture = (state_q == RUN) & lap;
    assign flush   = (state_q == IDLE) & start;
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE:     state_d = start ? RUN : IDLE;
            RUN:      state_d = start ? PAUSE : lap ? LAP_VIEW : RUN;
            LAP_VIEW: state_d = start ? PAUSE : lap ? RUN : LAP_VIEW;
            default: begin
                state_d = start ? RUN : lap ? IDLE : PAUSE;
                clr_d   = lap;
            end
        endcase
    end
    // run_en follows the next state so gating changes on the same edge as state
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q  <= IDLE;
            run_en   <= 1'b0;
            clr_q    <= 1'b0;
            lap_hold <= '0;
        end else begin
            state_q  <= state_d;
            run_en   <= (state_d == RUN) || (state_d == LAP_VIEW);
            clr_q    <= clr_d;
            if (capture) lap_hold <= bus.time_bcd;
        end
    end
    assign bus.tick_out  = bus.tick_usec & run_en;
    assign bus.cnt_clear = clr_q;
    assign bus.state     = state_q;
`ifdef SW_LAP_RECALL_EN
    logic [15:0]   lap_buf [LAP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_idx, oldest, newest;
    logic [AW:0]   lap_cnt;
    logic          recall;
    // when full the low bits of lap_cnt are 0, so oldest == wr_ptr (next slot to overwrite)
    assign oldest = wr_ptr - lap_cnt[AW-1:0];
    assign newest = wr_ptr - 1'b1;
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < LAP_DEPTH; i++) lap_buf[i] <= '0;
            wr_ptr  <= '0;
            rd_idx  <= '0;
            lap_cnt <= '0;
            recall  <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            lap_cnt <= '0;
            recall  <= 1'b0;
        end else if (capture) begin
            lap_buf[wr_ptr] <= bus.time_bcd;
            wr_ptr          <= wr_ptr + 1'b1;
            if (lap_cnt != (AW+1)'(LAP_DEPTH)) lap_cnt <= lap_cnt + 1'b1;
        end else if ((state_q == IDLE) && lap && (lap_cnt != '0)) begin
            if (!recall) begin
                recall <= 1'b1;
                rd_idx <= oldest;
            end else if (rd_idx == newest) recall <= 1'b0;
            else rd_idx <= rd_idx + 1'b1;
        end
    end
    assign bus.lap_count     = lap_cnt;
    assign bus.recall_active = recall;
    assign bus.disp_value    = (state_q == LAP_VIEW) ? lap_hold : recall ? lap_buf[rd_idx] : bus.time_bcd;
`else
    logic lap_flag;
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) lap_flag <= 1'b0;
        else if (flush) lap_flag <= 1'b0;
        else if (capture) lap_flag <= 1'b1;
    end
    assign bus.lap_count     = (AW+1)'(lap_flag);
    assign bus.recall_active = 1'b0;
    assign bus.disp_value    = (state_q == LAP_VIEW) ? lap_hold : bus.time_bcd;
`endif
endmodule

// File: tb/tb_stopwatch_seq_ctrl.sv
// tb_stopwatch_seq_ctrl: directed self-checking bench for stopwatch_seq_ctrl (LAP_DEPTH=4)
module tb_stopwatch_seq_ctrl;
    logic clk = 1'b0;
    logic reset_p;
    int   n_cmp = 0;
    int   n_err = 0;
    int   ticks;
    logic tick_seen;
    always #5 clk = ~clk;
    stopwatch_seq_ctrl_if #(.LAP_DEPTH(4)) bus ();
    stopwatch_seq_ctrl #(.LAP_DEPTH(4)) dut (.clk(clk), .reset_p(reset_p), .bus(bus));
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    // drive inputs for one cycle, note gated tick before the edge, then settle after the edge
    task automatic cyc(input logic s, input logic l, input logic t);
        @(negedge clk);
        bus.btn_start_p = s;
        bus.btn_lap_p   = l;
        bus.tick_usec   = t;
        #1 tick_seen = bus.tick_out;
        @(posedge clk);
        #1;
    endtask
    initial begin
        reset_p         = 1'b1;
        bus.btn_start_p = 1'b0;
        bus.btn_lap_p   = 1'b0;
        bus.tick_usec   = 1'b1;
        bus.time_bcd    = 16'h0042;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 2'b00);
        chk("rst_tick", bus.tick_out, 1'b0);
        chk("rst_clear", bus.cnt_clear, 1'b0);
        chk("rst_lapcnt", bus.lap_count, 3'd0);
        chk("rst_recall", bus.recall_active, 1'b0);
        chk("rst_disp", bus.disp_value, 16'h0042);
        @(negedge clk);
        reset_p       = 1'b0;
        bus.tick_usec = 1'b0;
        // start, 5 ticks, stop
        cyc(1, 0, 1);
        chk("tick_before_run", tick_seen, 1'b0);
        chk("start_state", bus.state, 2'b01);
        ticks = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1);
            ticks += int'(tick_seen);
        end
        chk("ticks_passed", ticks, 5);
        cyc(1, 0, 0);
        chk("stop_state", bus.state, 2'b10);
        cyc(0, 0, 1);
        chk("tick_after_stop", tick_seen, 1'b0);
        cyc(0, 1, 0);
        chk("clr_state", bus.state, 2'b00);
        chk("clr_pulse", bus.cnt_clear, 1'b1);
        chk("clr_lapcnt", bus.lap_count, 3'd0);
        cyc(0, 0, 0);
        chk("clr_one_cycle", bus.cnt_clear, 1'b0);
        // lap freeze and release
        cyc(1, 0, 0);
        bus.time_bcd = 16'h1234;
        cyc(0, 1, 0);
        chk("lap_state", bus.state, 2'b11);
        bus.time_bcd = 16'h5678;
        #1 chk("lap_frozen", bus.disp_value, 16'h1234);
        cyc(0, 0, 1);
        chk("lapview_tick", tick_seen, 1'b1);
        cyc(0, 1, 0);
        chk("unlap_state", bus.state, 2'b01);
        chk("unlap_disp", bus.disp_value, 16'h5678);
        chk("unlap_lapcnt", bus.lap_count, 3'd1);
        // simultaneous start+lap in RUN: start wins, no capture
        bus.time_bcd = 16'h0001;
        cyc(1, 1, 0);
        chk("both_state", bus.state, 2'b10);
        chk("both_lapcnt", bus.lap_count, 3'd1);
        chk("both_disp", bus.disp_value, 16'h0001);
        cyc(0, 1, 0);
        chk("clr2_state", bus.state, 2'b00);
        chk("clr2_pulse", bus.cnt_clear, 1'b1);
        chk("clr2_lapcnt", bus.lap_count, 3'd1);
        // single-entry recall
        cyc(0, 1, 0);
`ifdef SW_LAP_RECALL_EN
        chk("recall1_active", bus.recall_active, 1'b1);
        chk("recall1_disp", bus.disp_value, 16'h1234);
`else
        chk("recall1_active", bus.recall_active, 1'b0);
        chk("recall1_disp", bus.disp_value, 16'h0001);
`endif
        cyc(0, 1, 0);
        chk("recall1_end", bus.recall_active, 1'b0);
        chk("recall1_live", bus.disp_value, 16'h0001);
        // five captures into a 4-deep buffer
        cyc(1, 0, 0);
        chk("restart_lapcnt", bus.lap_count, 3'd0);
        for (int i = 1; i <= 5; i++) begin
            bus.time_bcd = 16'(i);
            cyc(0, 1, 0);
            cyc(0, 1, 0);
        end
`ifdef SW_LAP_RECALL_EN
        chk("full_lapcnt", bus.lap_count, 3'd4);
`else
        chk("full_lapcnt", bus.lap_count, 3'd1);
`endif
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        chk("clr3_state", bus.state, 2'b00);
        bus.time_bcd = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0);
`ifdef SW_LAP_RECALL_EN
            chk("recall_disp", bus.disp_value, (i < 4) ? 16'(i + 2) : 16'h0000);
            chk("recall_active", bus.recall_active, (i < 4) ? 1'b1 : 1'b0);
            chk("recall_lapcnt", bus.lap_count, 3'd4);
`else
            chk("recall_disp", bus.disp_value, 16'h0000);
            chk("recall_active", bus.recall_active, 1'b0);
            chk("recall_lapcnt", bus.lap_count, 3'd1);
`endif
        end
        // asynchronous reset mid-RUN
        cyc(1, 0, 0);
        bus.time_bcd = 16'h0011;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        bus.time_bcd = 16'h0022;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
`ifdef SW_LAP_RECALL_EN
        chk("pre_rst_lapcnt", bus.lap_count, 3'd2);
`else
        chk("pre_rst_lapcnt", bus.lap_count, 3'd1);
`endif
        @(negedge clk);
        bus.time_bcd  = 16'h0099;
        bus.tick_usec = 1'b1;
        #1 chk("pre_rst_tick", bus.tick_out, 1'b1);
        #1 reset_p = 1'b1;
        #1;
        chk("arst_state", bus.state, 2'b00);
        chk("arst_tick", bus.tick_out, 1'b0);
        chk("arst_lapcnt", bus.lap_count, 3'd0);
        chk("arst_disp", bus.disp_value, 16'h0099);
        @(negedge clk);
        reset_p = 1'b0;
        cyc(1, 0, 0);
        chk("post_rst_state", bus.state, 2'b01);
        chk("post_rst_lapcnt", bus.lap_count, 3'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
